dlart_bridge: RTL and testbench

DLART_BRIDGE -- requirements
Module: dlart_bridge

---
 rtl/dlart_pkg.sv | 35 +++
 rtl/dlart_fifo.sv | 53 +++++
 rtl/dlart_bridge.sv | 144 ++++++++++++++
 tb/tb_dlart_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlart_pkg.sv
// ============================================================================
// Module  : dlart_pkg
// Brief   : Shared constants and helpers for the DL11-style console bridge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dlart_pkg;

  // CPU register index within a channel block (byte offset / 2)
  localparam logic [1:0] c_reg_rcsr = 2'd0;
  localparam logic [1:0] c_reg_rbuf = 2'd1;
  localparam logic [1:0] c_reg_xcsr = 2'd2;
  localparam logic [1:0] c_reg_xbuf = 2'd3;

  localparam int c_bit_done = 7;
  localparam int c_bit_ie   = 6;
  localparam int c_bit_ovr  = 15;

  localparam logic [1:0] c_host_stat = 2'd0;
  localparam logic [1:0] c_host_txd  = 2'd1;
  localparam logic [1:0] c_host_rxd  = 2'd2;
  localparam logic [1:0] c_host_clr  = 2'd3;

  // 8-byte block number of channel c's register window
  function automatic logic [18:0] chan_blk(input int c, input logic [21:0] con,
                                           input logic [21:0] ext);
    logic [21:0] b;
    b = (c == 0) ? con : ext + 22'(8 * (c - 1));
    return b[21:3];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dlart_fifo.sv
// ============================================================================
// Module  : dlart_fifo
// Brief   : Byte-wide synchronous FIFO with fall-through head and flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dlart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_x3,
  input  logic       rstb,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [7:0]  r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign head  = r_mem[r_rptr[AW-1:0]];

  // A pop frees the slot in the same cycle, so a full FIFO still takes a push
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk_x3) begin
    if (rstb || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= din;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dlart_bridge.sv
// ============================================================================
// Module  : dlart_bridge
// Brief   : DL11-style console channels bridging the CPU bus to an Apple II host.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dlart_bridge
  import dlart_pkg::*;
#(
  parameter int          NCH      = 1,
  parameter int          DEPTH    = 16,
  parameter logic [21:0] CON_BASE = 22'o17777560,
  parameter logic [21:0] EXT_BASE = 22'o17776500
) (
  input  logic        clk_x3,
  input  logic        rstb,
  input  logic        bus_init,
  input  logic [21:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_byte,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_hit,
  input  logic        host_rd,
  input  logic        host_wr,
  input  logic [3:0]  host_a,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        irq_req
);

  logic           w_clr;
  logic [1:0]     w_cpu_reg;
  logic [1:0]     w_host_reg;
  logic [NCH-1:0] w_hit;
  logic [NCH-1:0] w_irq;
  logic [15:0]    w_cpu_val  [NCH];
  logic [7:0]     w_host_val [NCH];
  logic [15:0]    w_cpu_mux;
  logic [7:0]     w_host_mux;
  logic [15:0]    r_cpu_rdata;
  logic [7:0]     r_host_rdata;
  logic           r_irq;
  logic           w_unused;

  assign w_clr      = rstb | bus_init;
  assign w_cpu_reg  = cpu_addr[2:1];
  assign w_host_reg = host_a[1:0];
  assign w_unused   = &{1'b0, cpu_wdata[15:8]};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic       w_sel, w_cpu_rd, w_cpu_wr, w_hsel, w_host_rd, w_host_wr;
    logic       w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_ovr_set;
    logic [7:0] w_rx_head, w_tx_head;
    logic       w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic       r_rx_ie, r_tx_ie, r_ovr;

    assign w_sel     = (cpu_addr[21:3] == chan_blk(c, CON_BASE, EXT_BASE));
    assign w_hit[c]  = w_sel;
    assign w_cpu_rd  = cpu_rd & w_sel;
    assign w_cpu_wr  = cpu_wr & w_sel;
    assign w_hsel    = (host_a[3:2] == 2'(c));
    assign w_host_rd = host_rd & w_hsel;
    assign w_host_wr = host_wr & w_hsel;

    assign w_rx_push = w_host_wr && (w_host_reg == c_host_rxd);
    assign w_rx_pop  = w_cpu_rd && (w_cpu_reg == c_reg_rbuf);
    assign w_tx_push = w_cpu_wr && (w_cpu_reg == c_reg_xbuf) && !(cpu_byte && cpu_addr[0]);
    assign w_tx_pop  = w_host_rd && (w_host_reg == c_host_txd);
    // A push that lands alongside a pop is accepted, so it is not an overrun
    assign w_ovr_set = w_rx_push & w_rx_full & ~w_rx_pop;

    dlart_fifo #(.DEPTH(DEPTH)) u_rx (
      .clk_x3(clk_x3), .rstb(rstb), .flush(bus_init),
      .push(w_rx_push), .pop(w_rx_pop), .din(host_wdata),
      .head(w_rx_head), .full(w_rx_full), .empty(w_rx_empty)
    );

    dlart_fifo #(.DEPTH(DEPTH)) u_tx (
      .clk_x3(clk_x3), .rstb(rstb), .flush(bus_init),
      .push(w_tx_push), .pop(w_tx_pop), .din(cpu_wdata[7:0]),
      .head(w_tx_head), .full(w_tx_full), .empty(w_tx_empty)
    );

    always_ff @(posedge clk_x3) begin
      if (w_clr) begin
        r_rx_ie <= 1'b0;
        r_tx_ie <= 1'b0;
        r_ovr   <= 1'b0;
      end else begin
        if (w_cpu_wr && (w_cpu_reg == c_reg_rcsr)) r_rx_ie <= cpu_wdata[c_bit_ie];
        if (w_cpu_wr && (w_cpu_reg == c_reg_xcsr)) r_tx_ie <= cpu_wdata[c_bit_ie];
        if (w_ovr_set)
          r_ovr <= 1'b1;
        else if ((w_cpu_wr && (w_cpu_reg == c_reg_rcsr)) ||
                 (w_host_wr && (w_host_reg == c_host_clr)))
          r_ovr <= 1'b0;
      end
    end

    assign w_cpu_val[c] =
      (w_cpu_reg == c_reg_rcsr) ? {r_ovr, 7'b0, ~w_rx_empty, r_rx_ie, 6'b0} :
      (w_cpu_reg == c_reg_rbuf) ? {8'b0, (w_rx_empty ? 8'h00 : w_rx_head)} :
      (w_cpu_reg == c_reg_xcsr) ? {8'b0, ~w_tx_full, r_tx_ie, 6'b0} : 16'h0000;

    assign w_host_val[c] =
      (w_host_reg == c_host_stat) ? {5'b0, r_ovr, w_rx_full, ~w_tx_empty} :
      (w_host_reg == c_host_txd)  ? (w_tx_empty ? 8'h00 : w_tx_head) : 8'h00;

    assign w_irq[c] = (r_rx_ie & ~w_rx_empty) | (r_tx_ie & ~w_tx_full);
  end

  always_comb begin
    w_cpu_mux  = 16'h0000;
    w_host_mux = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      if (w_hit[i]) w_cpu_mux = w_cpu_val[i];
      if (host_a[3:2] == i[1:0]) w_host_mux = w_host_val[i];
    end
  end

  assign cpu_hit = |w_hit;

  always_ff @(posedge clk_x3) begin
    if (w_clr) begin
      r_cpu_rdata  <= 16'h0000;
      r_host_rdata <= 8'h00;
      r_irq        <= 1'b0;
    end else begin
      if (cpu_rd)  r_cpu_rdata  <= w_cpu_mux;
      if (host_rd) r_host_rdata <= w_host_mux;
      r_irq <= |w_irq;
    end
  end

  assign cpu_rdata  = r_cpu_rdata;
  assign host_rdata = r_host_rdata;
  assign irq_req    = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_dlart_bridge.sv
// ============================================================================
// Module  : tb_dlart_bridge
// Brief   : Self-checking bench for dlart_bridge (NCH=2, DEPTH=4) with a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dlart_bridge;

  localparam int NCH   = 2;
  localparam int DEPTH = 4;

  logic        clk_x3 = 1'b0;
  logic        rstb = 1'b1, bus_init = 1'b0;
  logic [21:0] cpu_addr = '0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_byte = 1'b0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_hit;
  logic        host_rd = 1'b0, host_wr = 1'b0;
  logic [3:0]  host_a = '0;
  logic [7:0]  host_wdata = '0;
  logic [7:0]  host_rdata;
  logic        irq_req;

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel queues and control bits
  logic [7:0] m_rx [NCH][$];
  logic [7:0] m_tx [NCH][$];
  bit         m_rxie [NCH];
  bit         m_txie [NCH];
  bit         m_ovr  [NCH];

  dlart_bridge #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk_x3(clk_x3), .rstb(rstb), .bus_init(bus_init),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_byte(cpu_byte),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .host_rd(host_rd), .host_wr(host_wr), .host_a(host_a),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .irq_req(irq_req)
  );

  always #5 clk_x3 = ~clk_x3;

  function automatic logic [21:0] base(input int c);
    return (c == 0) ? 22'o17777560 : 22'o17776500 + 22'(8 * (c - 1));
  endfunction

  function automatic bit model_irq();
    bit r = 0;
    for (int c = 0; c < NCH; c++)
      r |= (m_rxie[c] && m_rx[c].size() != 0) || (m_txie[c] && m_tx[c].size() < DEPTH);
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_rx[c].delete(); m_tx[c].delete();
      m_rxie[c] = 0; m_txie[c] = 0; m_ovr[c] = 0;
    end
  endtask

  task automatic cpu_read(input logic [21:0] a, output logic [15:0] d);
    @(negedge clk_x3); cpu_addr = a; cpu_rd = 1'b1;
    @(posedge clk_x3); #1; cpu_rd = 1'b0; d = cpu_rdata;
  endtask

  task automatic cpu_write(input logic [21:0] a, input logic [15:0] wd, input logic bw);
    @(negedge clk_x3); cpu_addr = a; cpu_wdata = wd; cpu_byte = bw; cpu_wr = 1'b1;
    @(posedge clk_x3); #1; cpu_wr = 1'b0; cpu_byte = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] ha, output logic [7:0] d);
    @(negedge clk_x3); host_a = ha; host_rd = 1'b1;
    @(posedge clk_x3); #1; host_rd = 1'b0; d = host_rdata;
  endtask

  task automatic host_write(input logic [3:0] ha, input logic [7:0] wd);
    @(negedge clk_x3); host_a = ha; host_wdata = wd; host_wr = 1'b1;
    @(posedge clk_x3); #1; host_wr = 1'b0;
  endtask

  task automatic do_init();
    @(negedge clk_x3); bus_init = 1'b1;
    @(posedge clk_x3); #1; bus_init = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    logic [15:0] d;
    @(negedge clk_x3); rstb = 1'b1;
    repeat (2) @(posedge clk_x3);
    #1;
    checks++;
    if (cpu_rdata !== 16'h0 || host_rdata !== 8'h0 || irq_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: cpu_rdata=%h host_rdata=%h irq=%b required 0/0/0",
               cpu_rdata, host_rdata, irq_req);
    end
    @(negedge clk_x3); rstb = 1'b0;
    cpu_addr = base(0); #1;
    checks++;
    if (cpu_hit !== 1'b1) begin
      errors++; $display("FAIL hit_con: cpu_hit=%b required 1", cpu_hit);
    end
    cpu_read(base(0), d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reset_rcsr: got %h required 0000", d); end
    cpu_read(base(0) + 4, d);
    checks++;
    if (d !== 16'h0080) begin errors++; $display("FAIL reset_xcsr: got %h required 0080", d); end
  endtask

  task automatic test_tx_path();
    logic [7:0] h;
    do_init();
    cpu_write(22'o17777566, 16'h0041, 1'b0);
    host_read(4'h0, h);
    checks++;
    if (h !== 8'h01) begin errors++; $display("FAIL tx_stat1: got %h required 01", h); end
    host_read(4'h1, h);
    checks++;
    if (h !== 8'h41) begin errors++; $display("FAIL tx_data: got %h required 41", h); end
    host_read(4'h0, h);
    checks++;
    if (h !== 8'h00) begin errors++; $display("FAIL tx_stat0: got %h required 00", h); end
    cpu_write(22'o17777567, 16'h0052, 1'b1);
    host_read(4'h0, h);
    checks++;
    if (h !== 8'h00) begin errors++; $display("FAIL tx_oddbyte: got %h required 00", h); end
  endtask

  task automatic test_rx_path();
    logic [15:0] d;
    do_init();
    host_write(4'h2, 8'h0D);
    cpu_read(22'o17777560, d);
    checks++;
    if (d !== 16'h0080) begin errors++; $display("FAIL rx_rcsr1: got %h required 0080", d); end
    cpu_read(22'o17777562, d);
    checks++;
    if (d !== 16'h000D) begin errors++; $display("FAIL rx_rbuf: got %h required 000d", d); end
    cpu_read(22'o17777560, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL rx_rcsr0: got %h required 0000", d); end
    cpu_read(22'o17777562, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL rx_empty_rbuf: got %h required 0000", d); end
  endtask

  task automatic test_overrun();
    logic [15:0] d;
    do_init();
    for (int i = 0; i < 5; i++) host_write(4'h2, 8'(8'hA0 + i));
    cpu_read(base(0), d);
    checks++;
    if (d !== 16'h8080) begin errors++; $display("FAIL ovr_rcsr: got %h required 8080", d); end
    for (int i = 0; i < 4; i++) begin
      cpu_read(base(0) + 2, d);
      checks++;
      if (d !== 16'(8'hA0 + i)) begin
        errors++; $display("FAIL ovr_rbuf%0d: got %h required %h", i, d, 16'(8'hA0 + i));
      end
    end
    host_write(4'h3, 8'h00);
    cpu_read(base(0), d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL ovr_clear: got %h required 0000", d); end
  endtask

  task automatic test_irq_ch1();
    logic [15:0] d;
    do_init();
    cpu_write(22'o17776504, 16'h0040, 1'b0);
    @(posedge clk_x3); #1;
    checks++;
    if (irq_req !== 1'b1) begin errors++; $display("FAIL irq_on: got %b required 1", irq_req); end
    for (int i = 0; i < 4; i++) cpu_write(22'o17776506, 16'(i + 1), 1'b0);
    @(posedge clk_x3); #1;
    checks++;
    if (irq_req !== 1'b0) begin errors++; $display("FAIL irq_full: got %b required 0", irq_req); end
    cpu_read(22'o17776504, d);
    checks++;
    if (d !== 16'h0040) begin errors++; $display("FAIL xcsr_full: got %h required 0040", d); end
    @(negedge clk_x3); cpu_addr = 22'o17776510; #1;
    checks++;
    if (cpu_hit !== 1'b0) begin errors++; $display("FAIL hit_ch2: got %b required 0", cpu_hit); end
    cpu_read(22'o17776510, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL nohit_read: got %h required 0000", d); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] d;
    logic [7:0]  h;
    do_init();
    for (int i = 0; i < 4; i++) host_write(4'h2, 8'(8'h10 + i));
    @(negedge clk_x3);
    cpu_addr = base(0) + 2; cpu_rd = 1'b1; host_a = 4'h2; host_wdata = 8'h99; host_wr = 1'b1;
    @(posedge clk_x3); #1; cpu_rd = 1'b0; host_wr = 1'b0;
    checks++;
    if (cpu_rdata !== 16'h0010) begin
      errors++; $display("FAIL full_pushpop: got %h required 0010", cpu_rdata);
    end
    host_read(4'h0, h);
    checks++;
    if (h !== 8'h02) begin errors++; $display("FAIL full_pushpop_stat: got %h required 02", h); end
    @(negedge clk_x3);
    cpu_addr = base(0); cpu_wdata = 16'h0000; cpu_wr = 1'b1; host_a = 4'h2; host_wdata = 8'hAA; host_wr = 1'b1;
    @(posedge clk_x3); #1; cpu_wr = 1'b0; host_wr = 1'b0;
    cpu_read(base(0), d);
    checks++;
    if (d !== 16'h8080) begin errors++; $display("FAIL set_wins: got %h required 8080", d); end
    for (int i = 0; i < 4; i++) begin
      cpu_read(base(0) + 2, d);
      checks++;
      if (d !== ((i == 3) ? 16'h0099 : 16'(8'h11 + i))) begin
        errors++; $display("FAIL full_order%0d: got %h", i, d);
      end
    end
    do_init();
    @(negedge clk_x3);
    cpu_addr = base(0) + 2; cpu_rd = 1'b1; host_a = 4'h2; host_wdata = 8'h5A; host_wr = 1'b1;
    @(posedge clk_x3); #1; cpu_rd = 1'b0; host_wr = 1'b0;
    checks++;
    if (cpu_rdata !== 16'h0000) begin
      errors++; $display("FAIL empty_pushpop: got %h required 0000", cpu_rdata);
    end
    cpu_read(base(0) + 2, d);
    checks++;
    if (d !== 16'h005A) begin errors++; $display("FAIL empty_push_kept: got %h required 005a", d); end
  endtask

  task automatic test_bus_init();
    logic [15:0] d;
    logic [7:0]  h;
    do_init();
    for (int i = 0; i < 4; i++) cpu_write(base(0) + 6, 16'(8'h30 + i), 1'b0);
    cpu_write(base(0), 16'h0040, 1'b0);
    host_write(4'h2, 8'h77);
    host_read(4'h0, h);
    cpu_read(base(0), d);
    @(negedge clk_x3); bus_init = 1'b1; host_a = 4'h2; host_wdata = 8'h66; host_wr = 1'b1;
    @(posedge clk_x3); #1; bus_init = 1'b0; host_wr = 1'b0;
    checks++;
    if (cpu_rdata !== 16'h0 || host_rdata !== 8'h0 || irq_req !== 1'b0) begin
      errors++;
      $display("FAIL init_outputs: cpu_rdata=%h host_rdata=%h irq=%b required 0/0/0",
               cpu_rdata, host_rdata, irq_req);
    end
    for (int c = 0; c < NCH; c++) begin
      host_read(4'(c * 4), h);
      checks++;
      if (h !== 8'h00) begin errors++; $display("FAIL init_stat%0d: got %h required 00", c, h); end
    end
    cpu_read(base(0) + 4, d);
    checks++;
    if (d !== 16'h0080) begin errors++; $display("FAIL init_xcsr: got %h required 0080", d); end
    cpu_read(base(0), d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL init_rcsr: got %h required 0000", d); end
    checks++;
    if (irq_req !== 1'b0) begin errors++; $display("FAIL init_irq: got %b required 0", irq_req); end
    model_clear();
  endtask

  task automatic test_random();
    logic [15:0] d, exp16, wd;
    logic [7:0]  h, exp8;
    bit          exp_irq;
    int          op, c, r;
    bit          bw, odd;
    do_init();
    for (int n = 0; n < 600; n++) begin
      exp_irq = model_irq();
      op = $urandom_range(0, 3);
      wd = 16'($urandom);
      case (op)
        0: begin
          c = $urandom_range(0, NCH - 1);
          r = $urandom_range(0, 2);
          if (r == 0) exp16 = {m_ovr[c], 7'b0, m_rx[c].size() != 0, m_rxie[c], 6'b0};
          else if (r == 1) exp16 = (m_rx[c].size() != 0) ? {8'h00, m_rx[c].pop_front()} : 16'h0;
          else exp16 = {8'h00, m_tx[c].size() < DEPTH, m_txie[c], 6'b0};
          cpu_read(base(c) + 22'(2 * r), d);
          checks++;
          if (d !== exp16) begin
            errors++; $display("FAIL rnd_cpu_rd n=%0d ch%0d r%0d: got %h required %h", n, c, r, d, exp16);
          end
        end
        1: begin
          c = $urandom_range(0, NCH - 1);
          r = $urandom_range(0, 3);
          bw = (r == 3) ? 1'($urandom) : 1'b0;
          odd = bw ? 1'($urandom) : 1'b0;
          if (r == 0) begin m_rxie[c] = wd[6]; m_ovr[c] = 0; end
          else if (r == 2) m_txie[c] = wd[6];
          else if (r == 3 && !odd && m_tx[c].size() < DEPTH) m_tx[c].push_back(wd[7:0]);
          cpu_write(base(c) + 22'(2 * r) + 22'(odd), wd, bw);
        end
        2: begin
          c = $urandom_range(0, 3);
          r = $urandom_range(0, 1);
          if (c >= NCH) exp8 = 8'h00;
          else if (r == 0) exp8 = {5'b0, m_ovr[c], m_rx[c].size() == DEPTH, m_tx[c].size() != 0};
          else exp8 = (m_tx[c].size() != 0) ? m_tx[c].pop_front() : 8'h00;
          host_read(4'(c * 4 + r), h);
          checks++;
          if (h !== exp8) begin
            errors++; $display("FAIL rnd_host_rd n=%0d ch%0d r%0d: got %h required %h", n, c, r, h, exp8);
          end
        end
        default: begin
          c = $urandom_range(0, 3);
          r = ($urandom_range(0, 3) == 0) ? 3 : 2;
          if (c < NCH) begin
            if (r == 3) m_ovr[c] = 0;
            else if (m_rx[c].size() == DEPTH) m_ovr[c] = 1;
            else m_rx[c].push_back(wd[7:0]);
          end
          host_write(4'(c * 4 + r), wd[7:0]);
        end
      endcase
      checks++;
      if (irq_req !== exp_irq) begin
        errors++; $display("FAIL rnd_irq n=%0d: got %b required %b", n, irq_req, exp_irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_path();
    test_rx_path();
    test_overrun();
    test_irq_ch1();
    test_simultaneous();
    test_bus_init();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
